// File: rtl/sonar_ranger_pkg.sv
// sonar_pkg: shared definitions for the ultrasonic ranging front end.
//   - state_t        : measurement FSM states
//   - DEF_*          : default parameter values (125 MHz system clock)
//   - CYCLES_PER_CM  : echo-width clocks per centimetre of target distance
//   - cm_to_cycles() : converts a distance in cm into an echo width in clocks
package sonar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRIG,
    WAIT,
    MEAS
  } state_t;

  localparam int unsigned CYCLES_PER_CM = 7250;

  localparam int unsigned DEF_PERIOD_CYCLES  = 8_500_000;
  localparam int unsigned DEF_TRIG_CYCLES    = 3_000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4_000_000;
  localparam int unsigned DEF_NEAR_TH        = 42 * CYCLES_PER_CM;
  localparam int unsigned DEF_HYST           = 12_500;
  localparam int          DEF_W              = 33;

  function automatic int unsigned cm_to_cycles(input int unsigned cm);
    return cm * CYCLES_PER_CM;
  endfunction

endpackage

// File: rtl/sonar_ranger_if.sv
// sonar_ranger_if: sensor pins plus the per-measurement result bus.
//   echo        : raw sensor echo (asynchronous to clk)
//   trig        : sensor trigger
//   echo_width  : last measured echo-high duration in clocks
//   width_valid : one-cycle strobe when echo_width updates
//   timeout     : one-cycle strobe when a measurement fails
//   target_near : hysteresis-filtered proximity level
// modport master : the ranger (drives trig and results, reads echo)
// modport slave  : the sensor/consumer side
interface sonar_ranger_if #(
  parameter int W = sonar_pkg::DEF_W
);

  logic         echo;
  logic         trig;
  logic [W-1:0] echo_width;
  logic         width_valid;
  logic         timeout;
  logic         target_near;

  modport master (
    input  echo,
    output trig,
    output echo_width,
    output width_valid,
    output timeout,
    output target_near
  );

  modport slave (
    output echo,
    input  trig,
    input  echo_width,
    input  width_valid,
    input  timeout,
    input  target_near
  );

endinterface

// File: rtl/sonar_ranger_sync2.sv
// sync2: two-flop synchronizer for a single asynchronous input.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output, two clocks behind d
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sonar_ranger.sv
// sonar_ranger: periodic trigger generation and echo-width measurement for an
// HC-SR04-class ultrasonic sensor.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : sonar_ranger_if.master -- echo in; trig, echo_width, width_valid,
//         timeout, target_near out (all outputs registered)
// Each period the FSM fires one trigger pulse, waits for the echo rising edge,
// counts the echo-high time and publishes one result (width and/or timeout).
module sonar_ranger
  import sonar_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned NEAR_TH        = DEF_NEAR_TH,
  parameter int unsigned HYST           = DEF_HYST,
  parameter int          W              = DEF_W
) (
  input logic            clk,
  input logic            rst,
  sonar_ranger_if.master bus
);

  // A measurement (trigger + echo wait + echo high) must always finish inside
  // one period so the FSM is back in IDLE when the period counter wraps.
  if (64'(TRIG_CYCLES) + 64'(2) * 64'(TIMEOUT_CYCLES) >= 64'(PERIOD_CYCLES)) begin : g_param_check
    $error("sonar_ranger: TRIG_CYCLES + 2*TIMEOUT_CYCLES must be less than PERIOD_CYCLES");
  end

  localparam logic [W-1:0] PERIOD_LAST  = W'(PERIOD_CYCLES - 1);
  localparam logic [W-1:0] TRIG_LEN     = W'(TRIG_CYCLES);
  localparam logic [W-1:0] TIMEOUT_LAST = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] TIMEOUT_LEN  = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] NEAR_LEVEL   = W'(NEAR_TH);
  localparam logic [W-1:0] CLEAR_LEVEL  = W'(NEAR_TH + HYST);

  state_t       state;
  logic [W-1:0] period_cnt;
  logic [W-1:0] phase_cnt;
  logic [W-1:0] width_cnt;
  logic         echo_s;
  logic         echo_d;

  sync2 u_echo_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.echo),
    .q   (echo_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (period_cnt == PERIOD_LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  // phase_cnt counts trigger-high cycles in TRIG and elapsed wait cycles in
  // WAIT. echo_d is the previous echo_s, so an echo that is already high when
  // WAIT is entered never looks like a rising edge and runs into the timeout.
  // target_near only moves on a strobe cycle, from the width being published.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      phase_cnt       <= '0;
      width_cnt       <= '0;
      echo_d          <= 1'b0;
      bus.trig        <= 1'b0;
      bus.echo_width  <= '0;
      bus.width_valid <= 1'b0;
      bus.timeout     <= 1'b0;
      bus.target_near <= 1'b0;
    end else begin
      echo_d          <= echo_s;
      bus.width_valid <= 1'b0;
      bus.timeout     <= 1'b0;
      case (state)
        IDLE: begin
          if (period_cnt == '0) begin
            state     <= TRIG;
            bus.trig  <= 1'b1;
            phase_cnt <= W'(1);
          end
        end
        TRIG: begin
          if (phase_cnt == TRIG_LEN) begin
            state     <= WAIT;
            bus.trig  <= 1'b0;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (echo_s && !echo_d) begin
            state     <= MEAS;
            width_cnt <= W'(1);
          end else if (phase_cnt == TIMEOUT_LAST) begin
            state           <= IDLE;
            bus.timeout     <= 1'b1;
            bus.target_near <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        MEAS: begin
          if (!echo_s) begin
            state           <= IDLE;
            bus.echo_width  <= width_cnt;
            bus.width_valid <= 1'b1;
            if (width_cnt < NEAR_LEVEL) begin
              bus.target_near <= 1'b1;
            end else if (width_cnt > CLEAR_LEVEL) begin
              bus.target_near <= 1'b0;
            end
          end else if (width_cnt == TIMEOUT_LAST) begin
            state           <= IDLE;
            bus.echo_width  <= TIMEOUT_LEN;
            bus.width_valid <= 1'b1;
            bus.timeout     <= 1'b1;
            bus.target_near <= 1'b0;
          end else begin
            width_cnt <= width_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_ranger.sv
// tb_sonar_ranger: self-checking bench for sonar_ranger with small parameters.
// A table of per-period echo scenarios with hand-derived results, a reset
// during measurement, then randomized periods scored by an event-level model.
module tb_sonar_ranger;

  localparam int PER = 200;
  localparam int TRG = 10;
  localparam int TMO = 80;
  localparam int NTH = 40;
  localparam int HY  = 5;
  localparam int W   = 33;

  typedef struct {
    int           start;
    int           len;
    logic [W-1:0] width;
    logic         valid;
    logic         tmo;
    logic         near;
  } vec_t;

  logic clk;
  logic rst;

  int           nVec;
  int           nFail;
  logic [W-1:0] mWidth;
  logic         mNear;
  vec_t         vecs[10];

  sonar_ranger_if #(.W(W)) bus ();

  sonar_ranger #(
    .PERIOD_CYCLES  (PER),
    .TRIG_CYCLES    (TRG),
    .TIMEOUT_CYCLES (TMO),
    .NEAR_TH        (NTH),
    .HYST           (HY),
    .W              (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic level);
    bus.echo = level;
  endtask

  task automatic checkOutput(input string tag, input int e, input logic [W+3:0] exp);
    logic [W+3:0] act;
    act = {bus.trig, bus.echo_width, bus.width_valid, bus.timeout, bus.target_near};
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s cyc %0d: got trig=%b width=%0d valid=%b timeout=%b near=%b, want trig=%b width=%0d valid=%b timeout=%b near=%b",
               tag, e, act[W+3], act[W+2:3], act[2], act[1], act[0],
               exp[W+3], exp[W+2:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Spec-level outcome of one period: no echo -> wait timeout; echo at least
  // TMO long -> saturated width with both strobes; otherwise the echo length.
  function automatic void modelResult(input int n, input int len,
                                      input logic [W-1:0] oldW, input logic oldNear,
                                      output logic [W-1:0] w, output logic v,
                                      output logic t, output logic nr);
    if (n == 0) begin
      w = oldW; v = 1'b0; t = 1'b1; nr = 1'b0;
    end else if (len >= TMO) begin
      w = W'(TMO); v = 1'b1; t = 1'b1; nr = 1'b0;
    end else begin
      w = W'(len); v = 1'b1; t = 1'b0;
      if (len < NTH)           nr = 1'b1;
      else if (len > NTH + HY) nr = 1'b0;
      else                     nr = oldNear;
    end
  endfunction

  // One full period, cycle e = 1..PER counted from the edge that raises trig.
  // The echo pin is high from the negedge after edge n for len cycles. Results
  // appear 2 sync cycles + 1 sampling cycle after the echo ends, or when the
  // wait (starting after edge TRG+1) or the width count reaches TMO.
  task automatic runPeriod(input string tag, input int n, input int len,
                           input logic [W-1:0] newW, input logic v,
                           input logic t, input logic nr);
    int           ev;
    logic [W-1:0] oldW;
    logic         oldNear;
    oldW    = mWidth;
    oldNear = mNear;
    if (n == 0 || n < TRG - 1)
      ev = TRG + 1 + TMO;
    else if (len < TMO)
      ev = n + len + 3;
    else
      ev = n + TMO + 2;
    for (int e = 1; e <= PER; e++) begin
      @(negedge clk);
      checkOutput(tag, e, {e <= TRG,
                           (e >= ev) ? newW : oldW,
                           (e == ev) & v,
                           (e == ev) & t,
                           (e >= ev) ? nr : oldNear});
      applyStimulus(n != 0 && e >= n && e < n + len);
    end
    mWidth = newW;
    mNear  = nr;
  endtask

  initial begin
    logic [W-1:0] w;
    logic         v;
    logic         t;
    logic         nr;
    int           n;
    int           len;

    nVec   = 0;
    nFail  = 0;
    mWidth = '0;
    mNear  = 1'b0;
    rst    = 1'b1;
    applyStimulus(1'b0);

    vecs[0] = '{0,  0,   W'(0),  1'b0, 1'b1, 1'b0};
    vecs[1] = '{16, 30,  W'(30), 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16, 43,  W'(43), 1'b1, 1'b0, 1'b1};
    vecs[3] = '{16, 46,  W'(46), 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16, 43,  W'(43), 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16, 30,  W'(30), 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16, 120, W'(80), 1'b1, 1'b1, 1'b0};
    vecs[7] = '{5,  100, W'(80), 1'b0, 1'b1, 1'b0};
    vecs[8] = '{16, 30,  W'(30), 1'b1, 1'b0, 1'b1};
    vecs[9] = '{0,  0,   W'(30), 1'b0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    checkOutput("reset", 0, '0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      runPeriod($sformatf("vec%0d", i), vecs[i].start, vecs[i].len,
                vecs[i].width, vecs[i].valid, vecs[i].tmo, vecs[i].near);
    end

    // Reset 20 cycles into a measurement: outputs clear at once, no strobe.
    for (int e = 1; e <= 39; e++) begin
      @(negedge clk);
      checkOutput("pre_rst", e, {e <= TRG, mWidth, 1'b0, 1'b0, mNear});
      applyStimulus(e >= 16);
    end
    rst = 1'b1;
    #1;
    checkOutput("rst_async", 39, '0);
    applyStimulus(1'b0);
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      checkOutput("rst_hold", e, '0);
    end
    rst    = 1'b0;
    mWidth = '0;
    mNear  = 1'b0;
    runPeriod("post_rst", 16, 25, W'(25), 1'b1, 1'b0, 1'b1);

    for (int r = 0; r < 15; r++) begin
      case ($urandom_range(0, 3))
        0: begin n = 0; len = 0; end
        1: begin n = $urandom_range(12, 85); len = $urandom_range(1, 100); end
        2: begin n = $urandom_range(12, 85); len = $urandom_range(70, 100); end
        default: begin n = $urandom_range(12, 85); len = $urandom_range(35, 50); end
      endcase
      modelResult(n, len, mWidth, mNear, w, v, t, nr);
      runPeriod($sformatf("rand%0d", r), n, len, w, v, t, nr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/sonar_ranger.md
# sonar_ranger

Ultrasonic ranging front end: generates the periodic trigger pulse for the HC-SR04-class sensor, measures each echo pulse with a timeout, and publishes a latched echo width, a valid/timeout strobe pair and a hysteresis-filtered `target_near` flag. It sits directly upstream of the motor controller and replaces the free-running trigger and echo counters. The controller consumes only stable, per-measurement results instead of a live counter.

## Interface
- `PERIOD_CYCLES`, 8500000: measurement period in clocks (68 ms at 125 MHz).
- `TRIG_CYCLES`, 3000: trigger high time in clocks (24 µs).
- `TIMEOUT_CYCLES`, 4000000: limit for echo-wait and echo-high, each separately (32 ms).
- `NEAR_TH`, 304500: width below which the target is near (≈42 cm).
- `HYST`, 12500: clear hysteresis above `NEAR_TH` (≈1.7 cm).
- `W`, 33: width of all counters and of `echo_width`.
- `clk` in 1: system clock (125 MHz).
- `rst` in 1: reset, asynchronous and active-high.
- `echo` in 1: raw sensor echo; asynchronous to `clk`.
- `trig` out 1: sensor trigger.
- `echo_width` out W: last measured echo-high duration in clocks; holds between updates.
- `width_valid` out 1: one-cycle strobe when `echo_width` updates.
- `timeout` out 1: one-cycle strobe when a measurement fails.
- `target_near` out 1: filtered proximity level.

## Operation
- `echo` passes through a 2-flop synchronizer. All logic uses the synchronized copy, `echo_s`.
- Period counter: free-running from 0 to `PERIOD_CYCLES`−1, then wraps to 0. The wrap to 0 starts a new measurement.
- FSM states and transitions:
  - IDLE: go to TRIG when the period counter is 0.
  - TRIG: `trig`=1 for exactly `TRIG_CYCLES` cycles, then go to WAIT.
  - WAIT: watch for `echo_s` low→high.
    - Rising edge: go to MEAS, with the width counter at 1.
    - No edge after `TIMEOUT_CYCLES` cycles: pulse `timeout`, go to IDLE.
  - MEAS: increment the width counter each cycle `echo_s`=1.
    - `echo_s` falls: latch the count into `echo_width`, pulse `width_valid`, go to IDLE.
    - Count reaches `TIMEOUT_CYCLES`: latch `TIMEOUT_CYCLES`, pulse both `width_valid` and `timeout`, go to IDLE.
- If `echo_s` is already high on entry to WAIT, the bench sees no edge. This is a stale echo and ends in the WAIT timeout.
- The width counter saturates by construction and never wraps.
- Parameter rule: `TRIG_CYCLES` + 2·`TIMEOUT_CYCLES` < `PERIOD_CYCLES`. The FSM is therefore always in IDLE at a period wrap. Check this with an elaboration-time assertion.
- `target_near` updates only on a `width_valid` or `timeout` cycle:
  - Set when the new width < `NEAR_TH`.
  - Clear when the new width > `NEAR_TH`+`HYST`, or on `timeout`.
  - Otherwise hold its value.

## Timing
- Reset values:
  - `trig`=0, `echo_width`=0, `width_valid`=0, `timeout`=0, `target_near`=0.
  - FSM in IDLE; period counter 0; synchronizer flops 0.
- After reset deasserts, `trig` rises on the first clock edge (period counter 0 → TRIG).
- `trig` is registered: high for exactly `TRIG_CYCLES` consecutive cycles per period.
- Echo latency: 2 cycles from the pin to `echo_s`.
- `width_valid` asserts on the cycle after the first sampled `echo_s`=0 in MEAS.
- `echo_width` equals the number of cycles `echo_s` was high.
- `echo_width` and `target_near` change on the same edge that asserts `width_valid`. Both are stable at least until the next strobe.
- Reset mid-measurement: all outputs return to their reset values immediately (asynchronously). The partial measurement is discarded; no strobe fires.
- `width_valid` and `timeout` are never high in two consecutive cycles.

## Structure
- Package `sonar_pkg` holds:
  - the FSM state enum (IDLE, TRIG, WAIT, MEAS);
  - the default parameter constants;
  - the cm-to-cycles conversion constant (7250 cycles/cm at 125 MHz).
- Sub-module `sync2`: 2-flop synchronizer with async reset, reused for `start` and `color` elsewhere.
- Period counter, FSM, width counter and hysteresis register live in `sonar_ranger`.

## Test plan
Use small parameters for every scenario: PERIOD=200, TRIG=10, TIMEOUT=80, NEAR_TH=40, HYST=5.
- Reset release, no echo:
  - `trig` high for cycles 1–10, then low.
  - `timeout` pulses 80 cycles after `trig` falls; `width_valid` stays 0.
  - `trig` repeats every 200 cycles.
- Echo high 30 cycles, starting 5 cycles after `trig` falls:
  - `echo_width`=30 with a single `width_valid` strobe.
  - `target_near`=1.
- Hysteresis sequence, widths 30, 43, 46, 43:
  - `target_near` is 1, 1, 0, 0.
- Echo held high 120 cycles:
  - `echo_width`=80; `width_valid` and `timeout` pulse on the same cycle.
  - `target_near`=0.
- Echo already high when `trig` falls, staying high 100 cycles:
  - no `width_valid`; `timeout` after 80 cycles.
- `rst` asserted during MEAS (20 cycles into echo):
  - all outputs 0 in the same cycle, no strobe.
  - After release, the next measurement of 25 cycles reports `echo_width`=25.
